// File: rtl/mandelbrot_pkg.sv
// Shared types and default frame geometry for the Mandelbrot coordinate generator.
package mandelbrot_pkg;
    localparam int COORD_W = 27;
    localparam int H_RES   = 640;
    localparam int V_RES   = 480;
    localparam int ADDR_W  = 19;

    typedef logic signed [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/mandelbrot_coord_gen_stepper.sv
// One coordinate axis: captures a base and a step at load, then walks the running
// coordinate by repeated two's-complement adds (wraps silently), or jumps back to base.
module coord_axis_stepper #(
    parameter int W = mandelbrot_pkg::COORD_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic [W-1:0] step_i,
    input  logic         advance_i,
    input  logic         rebase_i,
    output logic [W-1:0] coord_o
);
    logic [W-1:0] base_q, base_d;
    logic [W-1:0] step_q, step_d;
    logic [W-1:0] coord_q, coord_d;

    // Next-state: load wins over rebase, rebase wins over advance.
    always_comb begin
        base_d  = base_q;
        step_d  = step_q;
        coord_d = coord_q;
        if (load_i) begin
            base_d  = load_val_i;
            step_d  = step_i;
            coord_d = load_val_i;
        end else if (rebase_i) begin
            coord_d = base_q;
        end else if (advance_i) begin
            coord_d = coord_q + step_q;
        end else begin
            coord_d = coord_q;
        end
    end

    // Axis registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q  <= '0;
            step_q  <= '0;
            coord_q <= '0;
        end else begin
            base_q  <= base_d;
            step_q  <= step_d;
            coord_q <= coord_d;
        end
    end

    assign coord_o = coord_q;
endmodule

// File: rtl/mandelbrot_coord_gen.sv
// Raster-order coordinate generator: one complex coordinate per pixel over valid/ready,
// PIO words sampled only at start, frame walked incrementally without multipliers.
module mandelbrot_coord_gen #(
    parameter int DATA_W = mandelbrot_pkg::COORD_W,
    parameter int H_RES  = mandelbrot_pkg::H_RES,
    parameter int V_RES  = mandelbrot_pkg::V_RES,
    parameter int ADDR_W = mandelbrot_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       cr_initial,
    input  logic [31:0]       ci_initial,
    input  logic [31:0]       dx,
    input  logic [31:0]       dy,
    input  logic              start,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_cr,
    output logic [DATA_W-1:0] out_ci,
    output logic [9:0]        out_x,
    output logic [8:0]        out_y,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done
);
    import mandelbrot_pkg::*;

    localparam logic [9:0] X_LAST = 10'(H_RES - 1);
    localparam logic [8:0] Y_LAST = 9'(V_RES - 1);

    state_t              state_q, state_d;
    logic [9:0]          x_q, x_d;
    logic [8:0]          y_q, y_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                fire_s;
    logic                load_s;
    logic                adv_re_s;
    logic                rebase_re_s;
    logic                adv_im_s;
    logic                unused_pio_s;

    // PIO words are wider than the coordinate; the upper bits carry nothing.
    assign unused_pio_s = ^{cr_initial[31:DATA_W], ci_initial[31:DATA_W],
                            dx[31:DATA_W], dy[31:DATA_W]};

    assign fire_s = (state_q == RUN) && out_ready;

    // FSM next state plus raster counters and axis control.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        addr_d      = addr_q;
        load_s      = 1'b0;
        adv_re_s    = 1'b0;
        rebase_re_s = 1'b0;
        adv_im_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    x_d     = 10'd0;
                    y_d     = 9'd0;
                    addr_d  = '0;
                    load_s  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (!fire_s) begin
                    state_d = RUN;
                end else if (x_q != X_LAST) begin
                    x_d      = x_q + 10'd1;
                    addr_d   = addr_q + ADDR_W'(1);
                    adv_re_s = 1'b1;
                end else if (y_q != Y_LAST) begin
                    x_d         = 10'd0;
                    y_d         = y_q + 9'd1;
                    addr_d      = addr_q + ADDR_W'(1);
                    rebase_re_s = 1'b1;
                    adv_im_s    = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= 10'd0;
            y_q     <= 9'd0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
        end
    end

    coord_axis_stepper #(.W(DATA_W)) u_real (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load_s),
        .load_val_i (cr_initial[DATA_W-1:0]),
        .step_i     (dx[DATA_W-1:0]),
        .advance_i  (adv_re_s),
        .rebase_i   (rebase_re_s),
        .coord_o    (out_cr)
    );

    coord_axis_stepper #(.W(DATA_W)) u_imag (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load_s),
        .load_val_i (ci_initial[DATA_W-1:0]),
        .step_i     (dy[DATA_W-1:0]),
        .advance_i  (adv_im_s),
        .rebase_i   (1'b0),
        .coord_o    (out_ci)
    );

    assign out_valid = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign out_x     = x_q;
    assign out_y     = y_q;
    assign out_addr  = addr_q;
endmodule

// File: tb/tb_mandelbrot_coord_gen.sv
// Randomized self-checking bench: every beat is compared with coordinates computed
// directly as base + column*dx / base + row*dy modulo 2^DATA_W.
module tb_mandelbrot_coord_gen;
    localparam int DW   = 27;
    localparam int H    = 4;
    localparam int V    = 2;
    localparam int AW   = 19;
    localparam int NPIX = H * V;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   cr_initial, ci_initial, dx, dy;
    logic          start;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_cr, out_ci;
    logic [9:0]    out_x;
    logic [8:0]    out_y;
    logic [AW-1:0] out_addr;
    logic          busy, done;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_cr0, m_ci0, m_dx, m_dy;

    mandelbrot_coord_gen #(.DATA_W(DW), .H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .cr_initial (cr_initial),
        .ci_initial (ci_initial),
        .dx         (dx),
        .dy         (dy),
        .start      (start),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_cr     (out_cr),
        .out_ci     (out_ci),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_addr   (out_addr),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_cr(input int b);
        logic [63:0] t;
        t = 64'(m_cr0) + 64'(b % H) * 64'(m_dx);
        return t[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] exp_ci(input int b);
        logic [63:0] t;
        t = 64'(m_ci0) + 64'(b / H) * 64'(m_dy);
        return t[DW-1:0];
    endfunction

    // mode 0: ready always high; 1: pattern 1,0,0 repeating; 2: random ready.
    task automatic run_frame(input logic [31:0] cr0, input logic [31:0] ci0,
                             input logic [31:0] dxw, input logic [31:0] dyw,
                             input int mode, input bit chg_pio, input bit start_in_run,
                             input int abort_at);
        int beats;
        int cyc;
        bit r;
        @(negedge clk);
        cr_initial = cr0;
        ci_initial = ci0;
        dx         = dxw;
        dy         = dyw;
        start      = 1'b1;
        out_ready  = 1'($urandom_range(0, 1));
        m_cr0 = cr0[DW-1:0];
        m_ci0 = ci0[DW-1:0];
        m_dx  = dxw[DW-1:0];
        m_dy  = dyw[DW-1:0];
        @(negedge clk);
        start = 1'b0;
        beats = 0;
        cyc   = 0;
        while (beats < NPIX && cyc < 200) begin
            check("valid", 64'(out_valid), 64'd1);
            check("busy", 64'(busy), 64'd1);
            check("done_in_run", 64'(done), 64'd0);
            check("cr", 64'(out_cr), 64'(exp_cr(beats)));
            check("ci", 64'(out_ci), 64'(exp_ci(beats)));
            check("x", 64'(out_x), 64'(beats % H));
            check("y", 64'(out_y), 64'(beats / H));
            check("addr", 64'(out_addr), 64'(beats));
            if (abort_at >= 0 && beats == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check("rst_valid", 64'(out_valid), 64'd0);
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_addr", 64'(out_addr), 64'd0);
                check("rst_xy", 64'({out_x, out_y}), 64'd0);
                check("rst_cr", 64'(out_cr), 64'd0);
                return;
            end
            if (chg_pio && beats == 3) begin
                cr_initial = $urandom;
                ci_initial = $urandom;
                dx         = $urandom;
                dy         = $urandom;
            end
            start = start_in_run && (beats == 2);
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready = r;
            if (r) beats++;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        check("beat_count", 64'(beats), 64'(NPIX));
        check("done_pulse", 64'(done), 64'd1);
        check("done_valid", 64'(out_valid), 64'd0);
        check("done_busy", 64'(busy), 64'd0);
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("done_once", 64'(done), 64'd0);
        check("idle_valid", 64'(out_valid), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        out_ready  = 1'b0;
        cr_initial = 32'd0;
        ci_initial = 32'd0;
        dx         = 32'd0;
        dy         = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_coords", 64'({out_cr, out_ci}), 64'd0);
        check("reset_pos", 64'({out_x, out_y, out_addr}), 64'd0);
        reset = 1'b0;

        // Reference frame: -2.0+1.0i, steps +0.25 / -0.25.
        run_frame(32'h07000000, 32'h00800000, 32'h00200000, 32'h07E00000, 0, 1'b0, 1'b0, -1);
        // Stalled consumer.
        run_frame(32'h07000000, 32'h00800000, 32'h00200000, 32'h07E00000, 1, 1'b0, 1'b0, -1);
        // PIO words rewritten mid-frame, then a frame with new words.
        run_frame(32'h07000000, 32'h00800000, 32'h00200000, 32'h07E00000, 0, 1'b1, 1'b0, -1);
        run_frame(32'h07400000, 32'h00400000, 32'h00100000, 32'h07F00000, 2, 1'b0, 1'b0, -1);
        // start pulsed while running.
        run_frame(32'h07000000, 32'h00800000, 32'h00200000, 32'h07E00000, 2, 1'b0, 1'b1, -1);
        // reset after three beats, then a clean restart.
        run_frame(32'h07000000, 32'h00800000, 32'h00200000, 32'h07E00000, 0, 1'b0, 1'b0, 3);
        run_frame(32'h07000000, 32'h00800000, 32'h00200000, 32'h07E00000, 0, 1'b0, 1'b0, -1);
        // Positive-max real start wraps to most negative on the second beat.
        run_frame(32'h03FFFFFF, 32'h00000000, 32'h00000001, 32'h00000001, 0, 1'b0, 1'b0, -1);
        check("wrap_model", 64'(exp_cr(1)), 64'h4000000);

        for (int i = 0; i < 6; i++) begin
            run_frame($urandom, $urandom, $urandom, $urandom, 2,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
